state_decode__poly_frombytes: RTL and testbench



---
 rtl/state_decode__poly_frombytes_if.sv | 37 +++
 rtl/state_decode__poly_frombytes.sv | 111 +++++++++++
 tb/tb_state_decode__poly_frombytes.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/state_decode__poly_frombytes_if.sv
// Bus bundle for the 12-to-16-bit polynomial unpacker.
// Coeff_Range_err exists only when POLY_DECODE_RANGE_CHECK_EN is defined.
interface state_decode__poly_frombytes_if #(
    parameter int KYBER_N        = 256,
    parameter int i_Coeffs_Width = 12,
    parameter int o_Coeffs_Width = 16
);
    localparam int i_Poly_Size = i_Coeffs_Width * KYBER_N;
    localparam int o_Poly_Size = o_Coeffs_Width * KYBER_N;

    logic                   enable;
    logic [i_Poly_Size-1:0] iPoly;
    logic [o_Poly_Size-1:0] oPoly;
    logic                   Poly_Decode_done;

`ifdef POLY_DECODE_RANGE_CHECK_EN
    logic                   Coeff_Range_err;

    modport master (
        output enable, iPoly,
        input  oPoly, Poly_Decode_done, Coeff_Range_err
    );
    modport slave (
        input  enable, iPoly,
        output oPoly, Poly_Decode_done, Coeff_Range_err
    );
`else
    modport master (
        output enable, iPoly,
        input  oPoly, Poly_Decode_done
    );
    modport slave (
        input  enable, iPoly,
        output oPoly, Poly_Decode_done
    );
`endif
endinterface

// File: rtl/state_decode__poly_frombytes.sv
// Unpacks a 12-bit-per-coefficient polynomial into 16-bit coefficients, two per cycle.
// Optional feature POLY_DECODE_RANGE_CHECK_EN folds values >= KYBER_Q and flags Coeff_Range_err.
module state_decode__poly_frombytes #(
    parameter int KYBER_N        = 256,
    parameter int KYBER_Q        = 3329,
    parameter int i_Coeffs_Width = 12,
    parameter int o_Coeffs_Width = 16,
    parameter int i_Poly_Size    = i_Coeffs_Width * KYBER_N,
    parameter int o_Poly_Size    = o_Coeffs_Width * KYBER_N
) (
    input  logic                           clk,
    input  logic                           reset_n,
    state_decode__poly_frombytes_if.slave  bus
);
    localparam int                CNT_W     = $clog2(KYBER_N / 2);
    localparam logic [CNT_W-1:0]  LAST_PAIR = CNT_W'(KYBER_N / 2 - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t                    state;
    logic [i_Poly_Size-1:0]    shift_reg;
    logic [CNT_W-1:0]          pair_cnt;
    logic [o_Poly_Size-1:0]    work_poly;
    logic [i_Coeffs_Width-1:0] raw_lo;
    logic [i_Coeffs_Width-1:0] raw_hi;
    logic [o_Coeffs_Width-1:0] coeff_lo;
    logic [o_Coeffs_Width-1:0] coeff_hi;

    function automatic logic [i_Coeffs_Width-1:0] fold_coeff(input logic [i_Coeffs_Width-1:0] c);
        return (c >= i_Coeffs_Width'(KYBER_Q)) ? c - i_Coeffs_Width'(KYBER_Q) : c;
    endfunction

    assign raw_lo = shift_reg[i_Coeffs_Width-1:0];
    assign raw_hi = shift_reg[2*i_Coeffs_Width-1:i_Coeffs_Width];

`ifdef POLY_DECODE_RANGE_CHECK_EN
    logic pair_oor;
    logic range_err_acc;

    // A single subtraction suffices: the 12-bit maximum is below 2*KYBER_Q.
    assign coeff_lo = o_Coeffs_Width'(fold_coeff(raw_lo));
    assign coeff_hi = o_Coeffs_Width'(fold_coeff(raw_hi));
    assign pair_oor = (raw_lo >= i_Coeffs_Width'(KYBER_Q)) || (raw_hi >= i_Coeffs_Width'(KYBER_Q));
`else
    assign coeff_lo = o_Coeffs_Width'(raw_lo);
    assign coeff_hi = o_Coeffs_Width'(raw_hi);
`endif

    // The newest pair enters at the top, so after KYBER_N/2 shifts pair 0 sits at the bottom.
    // NOTE: pure datapath with no reset; it is always fully rewritten before OUT copies it.
    always_ff @(posedge clk) begin
        if (state == DECODE) begin
            work_poly <= {coeff_hi, coeff_lo, work_poly[o_Poly_Size-1:2*o_Coeffs_Width]};
        end
    end

    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            shift_reg            <= '0;
            pair_cnt             <= '0;
            bus.oPoly            <= '0;
            bus.Poly_Decode_done <= 1'b0;
`ifdef POLY_DECODE_RANGE_CHECK_EN
            range_err_acc        <= 1'b0;
            bus.Coeff_Range_err  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.Poly_Decode_done <= 1'b0;
                    if (bus.enable) begin
                        shift_reg <= bus.iPoly;
                        pair_cnt  <= '0;
                        state     <= DECODE;
`ifdef POLY_DECODE_RANGE_CHECK_EN
                        range_err_acc       <= 1'b0;
                        bus.Coeff_Range_err <= 1'b0;
`endif
                    end
                end
                DECODE: begin
                    shift_reg <= shift_reg >> (2 * i_Coeffs_Width);
                    pair_cnt  <= pair_cnt + 1'b1;
`ifdef POLY_DECODE_RANGE_CHECK_EN
                    range_err_acc <= range_err_acc | pair_oor;
`endif
                    if (pair_cnt == LAST_PAIR) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    bus.oPoly            <= work_poly;
                    bus.Poly_Decode_done <= 1'b1;
`ifdef POLY_DECODE_RANGE_CHECK_EN
                    bus.Coeff_Range_err  <= range_err_acc;
`endif
                    state                <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_state_decode__poly_frombytes.sv
// Self-checking bench for state_decode__poly_frombytes: timeline model plus literal pins.
// Honours POLY_DECODE_RANGE_CHECK_EN the same way as the design.
module tb_state_decode__poly_frombytes;
    localparam int N   = 256;
    localparam int IW  = 12;
    localparam int OW  = 16;
    localparam int Q   = 3329;
    localparam int IPS = IW * N;
    localparam int OPS = OW * N;
    localparam int RUN_EDGES = 129;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    state_decode__poly_frombytes_if bus ();

    state_decode__poly_frombytes dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic check_poly(input string name, input logic [OPS-1:0] act, input logic [OPS-1:0] req);
        int first;
        first = -1;
        n_checks++;
        if (act !== req) begin
            n_errors++;
            for (int j = 0; j < N; j++) begin
                if (first < 0 && act[OW*j +: OW] !== req[OW*j +: OW]) first = j;
            end
            $display("FAIL %s: coeff %0d got 0x%0h, expected 0x%0h", name, first,
                     act[OW*first +: OW], req[OW*first +: OW]);
        end
    endtask

    // Reference: coefficient j is the 12-bit field j, optionally reduced once modulo Q.
    function automatic logic [OPS-1:0] model_unpack(input logic [IPS-1:0] p);
        logic [OPS-1:0] r;
        int c;
        r = '0;
        for (int j = 0; j < N; j++) begin
            c = int'(p[IW*j +: IW]);
`ifdef POLY_DECODE_RANGE_CHECK_EN
            if (c >= Q) c = c - Q;
`endif
            r[OW*j +: OW] = OW'(c);
        end
        return r;
    endfunction

`ifdef POLY_DECODE_RANGE_CHECK_EN
    function automatic logic model_err(input logic [IPS-1:0] p);
        logic e;
        e = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (int'(p[IW*j +: IW]) >= Q) e = 1'b1;
        end
        return e;
    endfunction
`endif

    function automatic logic [IPS-1:0] rand_poly(input int max_val);
        logic [IPS-1:0] p;
        for (int j = 0; j < N; j++) p[IW*j +: IW] = IW'($urandom_range(max_val, 0));
        return p;
    endfunction

    // Timeline model: a start captures the input, the result appears 129 edges later.
    logic [IPS-1:0] m_cap   = '0;
    int             m_left  = 0;
    logic [OPS-1:0] m_opoly = '0;
    logic           m_done  = 1'b0;
`ifdef POLY_DECODE_RANGE_CHECK_EN
    logic           m_err   = 1'b0;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left  <= 0;
            m_opoly <= '0;
            m_done  <= 1'b0;
`ifdef POLY_DECODE_RANGE_CHECK_EN
            m_err   <= 1'b0;
`endif
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (bus.enable) begin
                    m_cap  <= bus.iPoly;
                    m_left <= RUN_EDGES;
`ifdef POLY_DECODE_RANGE_CHECK_EN
                    m_err  <= 1'b0;
`endif
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_opoly <= model_unpack(m_cap);
                    m_done  <= 1'b1;
`ifdef POLY_DECODE_RANGE_CHECK_EN
                    m_err   <= model_err(m_cap);
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_done", 32'(bus.Poly_Decode_done), 32'(m_done));
        check_poly("cyc_oPoly", bus.oPoly, m_opoly);
`ifdef POLY_DECODE_RANGE_CHECK_EN
        check("cyc_err", 32'(bus.Coeff_Range_err), 32'(m_err));
`endif
    end

    // One enable pulse; lat = edges from E0 to the edge that raised done.
    task automatic run(input logic [IPS-1:0] p, output int lat);
        @(negedge clk);
        bus.iPoly  = p;
        bus.enable = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.enable = 1'b0;
            if (bus.Poly_Decode_done === 1'b1) begin
                lat = i;
                break;
            end
        end
        @(negedge clk);
        check("done_fall", 32'(bus.Poly_Decode_done), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IPS-1:0] p;
        logic [IPS-1:0] p2;
        logic [OPS-1:0] o;
        int  lat;
        int  seen1;
        int  seen2;
        time t1;
        time t2;

        bus.enable = 1'b0;
        bus.iPoly  = '0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;

        // Pin the model with hand-computed values.
        p = '0;
        p[11:0]  = 12'hFFF;
        p[23:12] = 12'hD01;
        p[35:24] = 12'hD00;
        o = model_unpack(p);
`ifdef POLY_DECODE_RANGE_CHECK_EN
        check("model_fff", 32'(o[15:0]), 32'd766);
        check("model_d01", 32'(o[31:16]), 32'd0);
`else
        check("model_fff", 32'(o[15:0]), 32'd4095);
        check("model_d01", 32'(o[31:16]), 32'd3329);
`endif
        check("model_d00", 32'(o[47:32]), 32'd3328);

        @(negedge clk);
        check("reset_done", 32'(bus.Poly_Decode_done), 32'd0);
        check_poly("reset_oPoly", bus.oPoly, '0);

        // All-zero input.
        run('0, lat);
        check("lat_zero", lat, RUN_EDGES);
        check_poly("zero_out", bus.oPoly, '0);

        // Ramp: coefficient j holds j.
        for (int j = 0; j < N; j++) p[IW*j +: IW] = IW'(j);
        check("ramp_pack", 32'(p[23:0]), 32'h001000);
        run(p, lat);
        check("lat_ramp", lat, RUN_EDGES);
        o = bus.oPoly;
        check("ramp_c0", 32'(o[15:0]), 32'd0);
        check("ramp_c1", 32'(o[31:16]), 32'd1);
        check("ramp_c255", 32'(o[OW*255 +: OW]), 32'd255);
        check("ramp_c200_hi", 32'(o[OW*200+12 +: 4]), 32'd0);

        // Every coefficient at Q-1.
        for (int j = 0; j < N; j++) p[IW*j +: IW] = 12'hD00;
        run(p, lat);
        o = bus.oPoly;
        check("d00_c0", 32'(o[15:0]), 32'h0D00);
        check("d00_c128", 32'(o[OW*128 +: OW]), 32'h0D00);
`ifdef POLY_DECODE_RANGE_CHECK_EN
        check("d00_err", 32'(bus.Coeff_Range_err), 32'd0);
`endif

        // Random full-range polynomials.
        for (int r = 0; r < 3; r++) begin
            p = rand_poly(4095);
            run(p, lat);
            check("lat_rand", lat, RUN_EDGES);
            check_poly("rand_out", bus.oPoly, model_unpack(p));
        end

        // Two out-of-range coefficients among in-range data, then a clean run.
        p = rand_poly(Q - 1);
        p[IW*5 +: IW]   = 12'hFFF;
        p[IW*200 +: IW] = 12'hD01;
        run(p, lat);
        o = bus.oPoly;
`ifdef POLY_DECODE_RANGE_CHECK_EN
        check("oor_c5", 32'(o[OW*5 +: OW]), 32'd766);
        check("oor_c200", 32'(o[OW*200 +: OW]), 32'd0);
        check("oor_err", 32'(bus.Coeff_Range_err), 32'd1);
`else
        check("oor_c5", 32'(o[OW*5 +: OW]), 32'd4095);
        check("oor_c200", 32'(o[OW*200 +: OW]), 32'd3329);
`endif
        run(rand_poly(Q - 1), lat);
`ifdef POLY_DECODE_RANGE_CHECK_EN
        check("clean_err", 32'(bus.Coeff_Range_err), 32'd0);
`endif

        // Enable held high; input changes mid-run.
        p  = rand_poly(4095);
        p2 = rand_poly(4095);
        seen1 = 0;
        seen2 = 0;
        t1 = 0;
        t2 = 0;
        @(negedge clk);
        bus.iPoly  = p;
        bus.enable = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        bus.iPoly = p2;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.Poly_Decode_done === 1'b1) begin
                t1 = $time;
                seen1 = 1;
                break;
            end
        end
        check("held_seen1", seen1, 1);
        check_poly("held_first", bus.oPoly, model_unpack(p));
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.Poly_Decode_done === 1'b1) begin
                t2 = $time;
                seen2 = 1;
                break;
            end
        end
        bus.enable = 1'b0;
        check("held_seen2", seen2, 1);
        check("held_gap", 32'((t2 - t1) / 10), 32'd130);
        check_poly("held_second", bus.oPoly, model_unpack(p2));
        repeat (3) @(negedge clk);

        // Reset in the middle of a run.
        @(negedge clk);
        bus.iPoly  = rand_poly(4095);
        bus.enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (59) @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("rst_done", 32'(bus.Poly_Decode_done), 32'd0);
        check_poly("rst_oPoly", bus.oPoly, '0);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_idle_done", 32'(bus.Poly_Decode_done), 32'd0);
        p = rand_poly(4095);
        run(p, lat);
        check("lat_after_rst", lat, RUN_EDGES);
        check_poly("after_rst_out", bus.oPoly, model_unpack(p));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
